// File: rtl/lattice_pkg.sv
// lattice_pkg
//   Definitions shared by the lattice write-back (BRAM -> DDR) and receive
//   (DDR -> BRAM) pixel paths so both agree on the beat layout.
//   - NUM_DIRS / DATA_WIDTH : populations per pixel and bits per population
//   - DIR_N .. DIR_NW       : population slot index inside a packed beat
//   - dir_offset()          : LSB position of a population slot in a beat
//   - tx_state_t            : write-back sequencer states
package lattice_pkg;

  localparam int NUM_DIRS   = 9;
  localparam int DATA_WIDTH = 16;

  localparam int DIR_N    = 0;
  localparam int DIR_NULL = 1;
  localparam int DIR_NE   = 2;
  localparam int DIR_E    = 3;
  localparam int DIR_SE   = 4;
  localparam int DIR_S    = 5;
  localparam int DIR_SW   = 6;
  localparam int DIR_W    = 7;
  localparam int DIR_NW   = 8;

  function automatic int dir_offset(input int k, input int width = DATA_WIDTH);
    return width * k;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/lattice_axis_tx_if.sv
// lattice_axis_tx_if
//   Bundles the two buses of the lattice write-back block:
//   - BRAM read port : rd_en, rd_addr out; n1..nw1 data back one cycle later
//   - AXI-Stream     : m00_axis_tvalid/tready/tdata/tlast/tstrb
//   Modports: master = the streaming block, slave = BRAM + DMA side.
interface lattice_axis_tx_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 12
);

  localparam int TDATA_WIDTH = lattice_pkg::NUM_DIRS * DATA_WIDTH;

  logic                     rd_en;
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]    n1, null1, ne1, e1, se1, s1, sw1, w1, nw1;

  logic                     m00_axis_tvalid;
  logic                     m00_axis_tready;
  logic [TDATA_WIDTH-1:0]   m00_axis_tdata;
  logic                     m00_axis_tlast;
  logic [TDATA_WIDTH/8-1:0] m00_axis_tstrb;

  modport master (
    output rd_en, rd_addr,
    input  n1, null1, ne1, e1, se1, s1, sw1, w1, nw1,
    output m00_axis_tvalid, m00_axis_tdata, m00_axis_tlast, m00_axis_tstrb,
    input  m00_axis_tready
  );

  modport slave (
    input  rd_en, rd_addr,
    output n1, null1, ne1, e1, se1, s1, sw1, w1, nw1,
    input  m00_axis_tvalid, m00_axis_tdata, m00_axis_tlast, m00_axis_tstrb,
    output m00_axis_tready
  );

endinterface

// File: rtl/axis_skid_fifo.sv
// axis_skid_fifo
//   Two-entry FIFO that decouples BRAM read latency from AXI-Stream
//   backpressure. The head entry is presented directly from registers.
//   Ports:
//     clk, rst           : clock, asynchronous active-high reset
//     push, push_data    : write one entry ({last, data} payload)
//     pop                : consume the head entry
//     head_data          : current head entry
//     count, full, empty : occupancy
module axis_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_reg [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_reg[i] <= '0;
      end
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      // push and pop together leave the occupancy unchanged
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data = mem_reg[rd_ptr_reg];
  assign count     = count_reg;
  assign full      = (count_reg == 2'd2);
  assign empty     = (count_reg == 2'd0);

  overflow_chk: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
  underflow_chk: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/lattice_axis_tx.sv
// lattice_axis_tx
//   Streams one lattice frame (DEPTH pixels) from the lattice BRAM to the
//   DMA S2MM channel, one 9-population pixel per 144-bit AXI-Stream beat.
//   Ports:
//     m00_axis_aclk    : clock (rising edge)
//     m00_axis_aresetn : asynchronous reset, active HIGH despite its name
//     start            : one-cycle pulse, starts a frame when idle
//     busy             : frame in progress (start accepted .. last handshake)
//     done             : one-cycle pulse after the last beat handshakes
//     bus              : BRAM read port + AXI-Stream master (master modport)
module lattice_axis_tx #(
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH         = 2500,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic              m00_axis_aclk,
  input  logic              m00_axis_aresetn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  lattice_axis_tx_if.master bus
);

  import lattice_pkg::*;

  localparam int TDATA_WIDTH = NUM_DIRS * DATA_WIDTH;
  // one extra bit so the counter can hold DEPTH itself
  localparam int CNT_WIDTH   = ADDRESS_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0]     DEPTH_CNT = CNT_WIDTH'(DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  tx_state_t                state_reg;
  logic [CNT_WIDTH-1:0]     addr_cnt_reg;
  logic [CNT_WIDTH-1:0]     beat_cnt_reg;
  logic                     inflight_reg;
  logic [ADDRESS_WIDTH-1:0] cap_addr_reg;
  logic                     busy_reg;
  logic                     done_reg;

  logic                     issue;
  logic                     pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [1:0]               fifo_count;
  logic [TDATA_WIDTH:0]     push_data;
  logic [TDATA_WIDTH:0]     head_data;
  logic [TDATA_WIDTH-1:0]   packed_word;
  logic [DATA_WIDTH-1:0]    dir_word [NUM_DIRS];
  logic [ADDRESS_WIDTH-1:0] rd_addr;

  assign pop = !fifo_empty && bus.m00_axis_tready;

  // Credit check: entries already stored plus the read still in the BRAM
  // pipe, minus the one leaving this cycle, must leave room for one more.
  assign issue = (state_reg == ST_STREAM) && (addr_cnt_reg < DEPTH_CNT) &&
                 (({1'b0, fifo_count} + {2'b00, inflight_reg}) < (3'd2 + {2'b00, pop}));

  // Clamp so the address holds at DEPTH-1 once the frame has been issued.
  assign rd_addr = (addr_cnt_reg < DEPTH_CNT) ? addr_cnt_reg[ADDRESS_WIDTH-1:0] : LAST_ADDR;

  always_ff @(posedge m00_axis_aclk or posedge m00_axis_aresetn) begin
    if (m00_axis_aresetn) begin
      state_reg    <= ST_IDLE;
      addr_cnt_reg <= '0;
      beat_cnt_reg <= '0;
      inflight_reg <= 1'b0;
      cap_addr_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      inflight_reg <= issue;
      if (issue) begin
        cap_addr_reg <= rd_addr;
        addr_cnt_reg <= addr_cnt_reg + 1'b1;
      end
      if (pop) begin
        beat_cnt_reg <= beat_cnt_reg + 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg    <= ST_STREAM;
            addr_cnt_reg <= '0;
            beat_cnt_reg <= '0;
            busy_reg     <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (addr_cnt_reg == DEPTH_CNT) begin
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // head_data MSB is the stored last flag
          if (pop && head_data[TDATA_WIDTH]) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign dir_word[DIR_N]    = bus.n1;
  assign dir_word[DIR_NULL] = bus.null1;
  assign dir_word[DIR_NE]   = bus.ne1;
  assign dir_word[DIR_E]    = bus.e1;
  assign dir_word[DIR_SE]   = bus.se1;
  assign dir_word[DIR_S]    = bus.s1;
  assign dir_word[DIR_SW]   = bus.sw1;
  assign dir_word[DIR_W]    = bus.w1;
  assign dir_word[DIR_NW]   = bus.nw1;

  for (genvar gi = 0; gi < NUM_DIRS; gi++) begin : g_pack
    localparam int OFS = dir_offset(gi, DATA_WIDTH);
    assign packed_word[OFS +: DATA_WIDTH] = dir_word[gi];
  end

  assign push_data = {(cap_addr_reg == LAST_ADDR), packed_word};

  // BRAM data is valid the cycle after rd_en, i.e. while inflight_reg is set.
  axis_skid_fifo #(
    .WIDTH(TDATA_WIDTH + 1)
  ) u_fifo (
    .clk       (m00_axis_aclk),
    .rst       (m00_axis_aresetn),
    .push      (inflight_reg),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.rd_en           = issue;
  assign bus.rd_addr         = rd_addr;
  assign bus.m00_axis_tvalid = !fifo_empty;
  assign bus.m00_axis_tdata  = head_data[TDATA_WIDTH-1:0];
  assign bus.m00_axis_tlast  = head_data[TDATA_WIDTH];
  assign bus.m00_axis_tstrb  = '1;
  assign busy                = busy_reg;
  assign done                = done_reg;

  credit_chk: assert property (@(posedge m00_axis_aclk) disable iff (m00_axis_aresetn)
    !(fifo_full && inflight_reg && !pop));
  last_chk: assert property (@(posedge m00_axis_aclk) disable iff (m00_axis_aresetn)
    bus.m00_axis_tvalid |-> (bus.m00_axis_tlast == (beat_cnt_reg == DEPTH_CNT - 1'b1)));

endmodule

// File: tb/tb_lattice_axis_tx.sv
// tb_lattice_axis_tx
//   Three instances (DEPTH 4, 8, 2500) share clock and reset; one is
//   exercised at a time (sel). A negedge monitor compares every read address
//   and every beat against the expected frame: beat n carries the BRAM words
//   of address n, tlast only on beat DEPTH-1, data held while stalled.
module tb_lattice_axis_tx;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int TW = 9 * DW;
  localparam int SW = TW / 8;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start_s  [NI];
  logic          tready_s [NI];
  logic          rd_en_w  [NI];
  logic [AW-1:0] rd_addr_w[NI];
  logic          tvalid_w [NI];
  logic [TW-1:0] tdata_w  [NI];
  logic          tlast_w  [NI];
  logic [SW-1:0] tstrb_w  [NI];
  logic          busy_w   [NI];
  logic          done_w   [NI];

  int total = 0;
  int bad   = 0;
  logic [15:0] seed = 16'h1234;
  int sel = 0;
  logic mon_clear = 1'b0;

  int cyc, beat_n, read_n, busy_n, done_n, stall_reads;
  int first_read_cyc, last_read_cyc, first_beat_cyc;
  logic stalled;
  logic [TW-1:0] held_data;
  logic held_last;
  logic [TW-1:0] first_beat;

  function automatic int depth_of(input int s);
    case (s)
      0:       return 4;
      1:       return 8;
      default: return 2500;
    endcase
  endfunction

  // BRAM content: address 0 holds 1..9, everything else a seeded hash.
  function automatic logic [DW-1:0] bram_word(input int a, input int k, input logic [15:0] s);
    if (a == 0) return DW'(k + 1);
    return DW'((a * 40503 + k * 7919 + int'(s) * 13) ^ (a >> 3));
  endfunction

  function automatic logic [TW-1:0] exp_beat(input int a, input logic [15:0] s);
    logic [TW-1:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) v[k*DW +: DW] = bram_word(a, k, s);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int D = (gi == 0) ? 4 : ((gi == 1) ? 8 : 2500);
    lattice_axis_tx_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    lattice_axis_tx #(.DATA_WIDTH(DW), .DEPTH(D), .ADDRESS_WIDTH(AW)) dut (
      .m00_axis_aclk    (clk),
      .m00_axis_aresetn (rst),
      .start            (start_s[gi]),
      .busy             (busy_w[gi]),
      .done             (done_w[gi]),
      .bus              (bus)
    );

    always @(posedge clk) begin
      if (bus.rd_en) begin
        bus.n1    <= bram_word(int'(bus.rd_addr), 0, seed);
        bus.null1 <= bram_word(int'(bus.rd_addr), 1, seed);
        bus.ne1   <= bram_word(int'(bus.rd_addr), 2, seed);
        bus.e1    <= bram_word(int'(bus.rd_addr), 3, seed);
        bus.se1   <= bram_word(int'(bus.rd_addr), 4, seed);
        bus.s1    <= bram_word(int'(bus.rd_addr), 5, seed);
        bus.sw1   <= bram_word(int'(bus.rd_addr), 6, seed);
        bus.w1    <= bram_word(int'(bus.rd_addr), 7, seed);
        bus.nw1   <= bram_word(int'(bus.rd_addr), 8, seed);
      end
    end

    assign bus.m00_axis_tready = tready_s[gi];
    assign rd_en_w[gi]   = bus.rd_en;
    assign rd_addr_w[gi] = bus.rd_addr;
    assign tvalid_w[gi]  = bus.m00_axis_tvalid;
    assign tdata_w[gi]   = bus.m00_axis_tdata;
    assign tlast_w[gi]   = bus.m00_axis_tlast;
    assign tstrb_w[gi]   = bus.m00_axis_tstrb;
  end

  // Monitor: samples at negedge; inputs only change just after posedge.
  initial begin
    cyc = 0; beat_n = 0; read_n = 0; busy_n = 0; done_n = 0; stall_reads = 0;
    first_read_cyc = -1; last_read_cyc = -1; first_beat_cyc = -1;
    stalled = 1'b0; held_data = '0; held_last = 1'b0; first_beat = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_clear || rst) begin
        beat_n = 0; read_n = 0; busy_n = 0; done_n = 0; stall_reads = 0;
        first_read_cyc = -1; last_read_cyc = -1; first_beat_cyc = -1;
        stalled = 1'b0;
      end
      if (!rst) begin
        if (rd_en_w[sel]) begin
          chk("rd_addr", TW'(rd_addr_w[sel]), TW'(read_n));
          if (read_n == 0) first_read_cyc = cyc;
          last_read_cyc = cyc;
          read_n++;
          if (!tready_s[sel]) stall_reads++;
        end
        if (busy_w[sel]) busy_n++;
        if (done_w[sel]) done_n++;
        if (stalled) begin
          chk("hold_valid", TW'(tvalid_w[sel]), TW'(1));
          chk("hold_data", tdata_w[sel], held_data);
          chk("hold_last", TW'(tlast_w[sel]), TW'(held_last));
        end
        if (tvalid_w[sel] && tready_s[sel]) begin
          if (beat_n == 0) begin
            first_beat_cyc = cyc;
            first_beat = tdata_w[sel];
          end
          chk("beat_data", tdata_w[sel], exp_beat(beat_n, seed));
          chk("beat_last", TW'(tlast_w[sel]), TW'(beat_n == depth_of(sel) - 1));
          beat_n++;
        end
        stalled   = tvalid_w[sel] && !tready_s[sel];
        held_data = tdata_w[sel];
        held_last = tlast_w[sel];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input string tag);
    start_s[sel] = 1'b1;
    mon_clear = 1'b1;
    tick();
    start_s[sel] = 1'b0;
    mon_clear = 1'b0;
    chk({tag, "_busy"}, TW'(busy_w[sel]), TW'(1));
    chk({tag, "_rd_en"}, TW'(rd_en_w[sel]), TW'(1));
    chk({tag, "_rd_addr0"}, TW'(rd_addr_w[sel]), TW'(0));
  endtask

  task automatic wait_done(input int budget, input bit rand_rdy, input bit tail);
    int n;
    n = 0;
    while (done_n == 0 && n < budget) begin
      if (rand_rdy) tready_s[sel] = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("done_seen", TW'(done_n != 0), TW'(1));
    tready_s[sel] = 1'b1;
    if (tail) repeat (4) tick();
  endtask

  task automatic wait_beats(input int nb, input int budget);
    int n;
    n = 0;
    while (beat_n < nb && n < budget) begin
      tick();
      n++;
    end
    chk("beats_reached", TW'(beat_n >= nb), TW'(1));
  endtask

  initial begin
    int noisy;
    for (int i = 0; i < NI; i++) begin
      start_s[i] = 1'b0;
      tready_s[i] = 1'b1;
    end

    // reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_rd_en%0d", i), TW'(rd_en_w[i]), TW'(0));
      chk($sformatf("rst_rd_addr%0d", i), TW'(rd_addr_w[i]), TW'(0));
      chk($sformatf("rst_tvalid%0d", i), TW'(tvalid_w[i]), TW'(0));
      chk($sformatf("rst_tdata%0d", i), tdata_w[i], TW'(0));
      chk($sformatf("rst_tlast%0d", i), TW'(tlast_w[i]), TW'(0));
      chk($sformatf("rst_busy%0d", i), TW'(busy_w[i]), TW'(0));
      chk($sformatf("rst_done%0d", i), TW'(done_w[i]), TW'(0));
      chk($sformatf("rst_tstrb%0d", i), TW'(tstrb_w[i]), TW'(18'h3FFFF));
    end
    rst = 1'b0;
    noisy = 0;
    repeat (20) begin
      tick();
      for (int i = 0; i < NI; i++) if (rd_en_w[i] || tvalid_w[i]) noisy++;
    end
    chk("idle_quiet", TW'(noisy), TW'(0));
    $display("reset: checked, idle activity=%0d", noisy);

    // basic frame, DEPTH=4
    sel = 0; seed = 16'h0101;
    start_frame("basic");
    wait_done(50, 1'b0, 1'b1);
    chk("basic_beats", TW'(beat_n), TW'(4));
    chk("basic_reads", TW'(read_n), TW'(4));
    chk("basic_done_cnt", TW'(done_n), TW'(1));
    chk("basic_busy_len", TW'(busy_n), TW'(6));
    chk("basic_read_span", TW'(last_read_cyc - first_read_cyc), TW'(3));
    chk("basic_first_lat", TW'(first_beat_cyc - first_read_cyc), TW'(2));
    for (int k = 0; k < 9; k++)
      chk($sformatf("pack%0d", k), TW'(first_beat[k*DW +: DW]), TW'(k + 1));
    $display("frame basic: depth=4 beats=%0d reads=%0d busy=%0d", beat_n, read_n, busy_n);

    // backpressure, DEPTH=8
    sel = 1; seed = 16'h0bad;
    start_frame("bp");
    wait_beats(2, 50);
    tready_s[sel] = 1'b0;
    repeat (5) tick();
    chk("bp_stall_reads", TW'(stall_reads <= 2), TW'(1));
    tready_s[sel] = 1'b1;
    wait_done(100, 1'b0, 1'b1);
    chk("bp_beats", TW'(beat_n), TW'(8));
    chk("bp_done_cnt", TW'(done_n), TW'(1));
    $display("frame backpressure: depth=8 beats=%0d stall_reads=%0d", beat_n, stall_reads);

    // random tready, DEPTH=2500
    sel = 2; seed = 16'h5a5a;
    start_frame("rnd");
    wait_done(20000, 1'b1, 1'b1);
    chk("rnd_beats", TW'(beat_n), TW'(2500));
    chk("rnd_reads", TW'(read_n), TW'(2500));
    chk("rnd_done_cnt", TW'(done_n), TW'(1));
    $display("frame random: depth=2500 beats=%0d", beat_n);

    // second start while busy is ignored; start right after done restarts
    sel = 1; seed = 16'h3c3c;
    start_frame("sb");
    repeat (4) tick();
    start_s[sel] = 1'b1;
    tick();
    start_s[sel] = 1'b0;
    wait_done(100, 1'b0, 1'b0);
    chk("sb_beats", TW'(beat_n), TW'(8));
    chk("sb_reads", TW'(read_n), TW'(8));
    start_frame("again");
    wait_done(100, 1'b0, 1'b1);
    chk("again_beats", TW'(beat_n), TW'(8));
    chk("again_reads", TW'(read_n), TW'(8));
    chk("again_done_cnt", TW'(done_n), TW'(1));
    $display("frame restart: depth=8 beats=%0d", beat_n);

    // reset in mid-frame with a beat waiting
    sel = 1; seed = 16'h7777;
    start_frame("mid");
    wait_beats(3, 50);
    tready_s[sel] = 1'b0;
    repeat (2) tick();
    chk("mid_pre_valid", TW'(tvalid_w[sel]), TW'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", TW'(tvalid_w[sel]), TW'(0));
    chk("mid_rst_busy", TW'(busy_w[sel]), TW'(0));
    chk("mid_rst_rd_en", TW'(rd_en_w[sel]), TW'(0));
    chk("mid_rst_tdata", tdata_w[sel], TW'(0));
    repeat (2) tick();
    rst = 1'b0;
    seed = 16'h4242;
    tready_s[sel] = 1'b1;
    noisy = 0;
    repeat (3) begin
      tick();
      if (tvalid_w[sel]) noisy++;
    end
    chk("mid_no_stale", TW'(noisy), TW'(0));
    start_frame("post");
    wait_done(100, 1'b0, 1'b1);
    chk("post_beats", TW'(beat_n), TW'(8));
    chk("post_first", first_beat, exp_beat(0, seed));
    $display("frame after reset: depth=8 beats=%0d", beat_n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lattice_axis_tx.md
# lattice_axis_tx

- Streams one full lattice frame from the on-chip lattice BRAM out to DDR over a 144-bit AXI-Stream master.
- Each pixel is read once: its 9 direction populations (16 bits each) are packed into one beat, in the same bit layout the DDR-to-lattice receive path unpacks.
- It sits between the lattice BRAM read port and the DMA S2MM channel. It is the write-back counterpart of the DDR pixel input path.

## Interface
- DATA_WIDTH, 16, bits per direction population
- DEPTH, 2500, pixels per frame (beats per packet)
- ADDRESS_WIDTH, 12, BRAM address width; 2^ADDRESS_WIDTH >= DEPTH
- m00_axis_aclk  in  1  single clock; all logic rising-edge
- m00_axis_aresetn  in  1  asynchronous, active-high reset; the polarity is fixed despite the port name
- start  in  1  one-cycle pulse; starts a frame when idle
- rd_en  out  1  BRAM read enable
- rd_addr  out  ADDRESS_WIDTH  BRAM read address
- n1, null1, ne1, e1, se1, s1, sw1, w1, nw1  in  DATA_WIDTH each  BRAM read data, valid one cycle after rd_en
- m00_axis_tvalid  out  1  beat valid
- m00_axis_tready  in  1  DMA accepts beat
- m00_axis_tdata  out  9*DATA_WIDTH  packed pixel
- m00_axis_tlast  out  1  high on beat DEPTH-1
- m00_axis_tstrb  out  9*DATA_WIDTH/8  constant all ones
- busy  out  1  high from start acceptance until the last beat handshakes
- done  out  1  one-cycle pulse after the last handshake

## Operation
- FSM states:
  - IDLE: start=1 -> STREAM; clear addr_cnt and beat_cnt.
  - STREAM: issue reads; when addr_cnt==DEPTH -> DRAIN.
  - DRAIN: wait for the beat with tlast to handshake -> IDLE, pulse done.
- start is ignored outside IDLE.
- Read issue condition: state==STREAM && addr_cnt<DEPTH && (fifo_count + inflight - pop) < 2.
  - inflight is a register equal to the previous cycle's rd_en.
  - pop = tvalid && tready.
- On issue: rd_addr=addr_cnt, and addr_cnt increments.
- rd_addr is undefined-but-held when rd_en=0, and never exceeds DEPTH-1.
- Capture: the cycle after rd_en, the 9 inputs are packed and written to a 2-entry FIFO.
  - Packing: tdata[16k+15:16k] with k=0..8 carries n, null, ne, e, se, s, sw, w, nw in that order.
  - last flag = (captured address == DEPTH-1).
- The FIFO head drives tdata, tlast and tvalid (tvalid = FIFO non-empty).
- Simultaneous push and pop is allowed in the same cycle; the count is unchanged.
- The FIFO can never overflow, by construction of the issue condition. An overflow is an assertion failure.
- Reset in mid-frame: all state is cleared asynchronously, the in-flight BRAM read is discarded, and the next start restarts from address 0.

## Timing
- Reset values:
  - Outputs: rd_en=0, rd_addr=0, tvalid=0, tdata=0, tlast=0, busy=0, done=0; tstrb all ones.
  - Internal: FSM=IDLE, FIFO empty.
- Latency from start:
  - start sampled at edge E0 -> busy=1, rd_en=1, rd_addr=0 during the following cycle.
  - BRAM registers at E1.
  - FIFO captures at E2; tvalid=1 after E2.
- Throughput: with tready held 1, one beat per cycle sustained. The frame occupies DEPTH+2 cycles from E0 to the last handshake.
- done asserts the cycle after the tlast handshake; busy drops on the same edge.
- AXIS rules:
  - Once tvalid=1, tvalid, tdata and tlast stay stable until a handshake.
  - tvalid never depends combinationally on tready.
  - rd_en may depend combinationally on tready, through the pop credit.
- tready low for N cycles: issue stops within 2 reads, and resumes the cycle after the handshake.

## Structure
- Shared package lattice_pkg holds:
  - NUM_DIRS=9 and DATA_WIDTH.
  - Direction index constants DIR_N..DIR_NW (0..8) and the slice offset function 16*k.
  - The same package is used by the receive path.
- One sub-module, axis_skid_fifo: 2-entry FIFO with push, pop, count, full and empty, plus a {last, data} payload.

## Test plan
- Reset: hold reset 3 cycles -> every output at its reset value, tstrb=0x3FFFF. Release with no start -> rd_en and tvalid stay 0 for 20 cycles.
- Basic frame, DEPTH=4, tready=1:
  - start -> rd_addr 0,1,2,3 on consecutive cycles.
  - 4 back-to-back beats; tlast only on the 4th.
  - done pulses once, and busy spans exactly 6 cycles.
- Packing: BRAM model returns n1=0x0001 … nw1=0x0009 at address 0 -> tdata[15:0]=0x0001, tdata[31:16]=0x0002, …, tdata[143:128]=0x0009.
- Backpressure, DEPTH=8:
  - Drop tready for 5 cycles after beat 2 -> at most 2 reads issued during the stall.
  - tdata is held stable; all 8 beats arrive in address order with no loss or duplication.
  - Random 50% tready over DEPTH=2500 -> a scoreboard matches every beat.
- Start while busy: a second start pulse mid-frame -> ignored, the frame still has exactly DEPTH beats. A start the cycle after done -> a new frame starts from address 0.
- Reset mid-frame: assert reset at beat 3 with tvalid=1 and tready=0 -> tvalid=0 immediately. After release, start -> the first beat carries address 0 data with no stale beat.
